mdu_issue_scheduler: RTL and testbench

Issue scheduler for the pipelined multiply/divide unit (MDU). It sits between decode and the fixed-latency MUL (4-stage) and DIV (8-stage) pipes. It accepts MDU operations through a valid/ready handshake and stalls on register hazards. It reserves the single shared writeback slot so MUL and DIV results never collide, and it drives the start pulses and writeback metadata.

---
 rtl/mdu_issue_scheduler_pkg.sv | 29 ++
 rtl/mdu_issue_scheduler_if.sv | 32 +++
 rtl/mdu_issue_scheduler_meta_delay.sv | 35 +++
 rtl/mdu_issue_scheduler.sv | 105 ++++++++++
 tb/tb_mdu_issue_scheduler.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mdu_issue_scheduler_pkg.sv
// Shared MDU types and constants: pipe latencies, RV32M funct3 codes, writeback metadata.
package mdu_pkg;

   localparam int unsigned MUL_LAT_DEF = 4;
   localparam int unsigned DIV_LAT_DEF = 8;
   localparam int unsigned REG_W       = 5;
   localparam int unsigned F3_W        = 3;
   localparam int unsigned NREGS       = 32;

   localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
   localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
   localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
   localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
   localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
   localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
   localparam logic [F3_W-1:0] F3_REM    = 3'b110;
   localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

   typedef struct packed {
      logic            is_mul;
      logic [F3_W-1:0] funct3;
      logic [REG_W-1:0] rd;
   } mdu_meta_t;

   function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
      return NREGS'(1) << r;
   endfunction

endpackage

// File: rtl/mdu_issue_scheduler_if.sv
// Decode-side issue handshake plus writeback/scoreboard outputs of the MDU issue scheduler.
interface mdu_issue_scheduler_if;

   logic                        issue_valid;
   logic                        issue_ready;
   logic                        issue_is_mul;
   logic [mdu_pkg::F3_W-1:0]    issue_funct3;
   logic [mdu_pkg::REG_W-1:0]   issue_rd;
   logic [mdu_pkg::REG_W-1:0]   issue_rs1;
   logic [mdu_pkg::REG_W-1:0]   issue_rs2;
   logic                        mul_start;
   logic                        div_start;
   logic                        wb_valid;
   logic                        wb_is_mul;
   logic [mdu_pkg::F3_W-1:0]    wb_funct3;
   logic [mdu_pkg::REG_W-1:0]   wb_rd;
   logic [mdu_pkg::NREGS-1:0]   rd_pending;
   logic                        mdu_busy;

   modport master (
      output issue_valid, issue_is_mul, issue_funct3, issue_rd, issue_rs1, issue_rs2,
      input  issue_ready, mul_start, div_start, wb_valid, wb_is_mul, wb_funct3, wb_rd,
             rd_pending, mdu_busy
   );

   modport slave (
      input  issue_valid, issue_is_mul, issue_funct3, issue_rd, issue_rs1, issue_rs2,
      output issue_ready, mul_start, div_start, wb_valid, wb_is_mul, wb_funct3, wb_rd,
             rd_pending, mdu_busy
   );

endinterface

// File: rtl/mdu_issue_scheduler_meta_delay.sv
// Fixed-depth valid + metadata delay line shadowing one MDU pipe.
module mdu_meta_delay
   import mdu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      valid_i,
   input  mdu_meta_t meta_i,
   output logic      valid_o,
   output mdu_meta_t meta_o
);

   logic [DEPTH-1:0] vld_q;
   mdu_meta_t        meta_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) meta_q[i] <= '0;
      end else begin
         vld_q[0]  <= valid_i;
         meta_q[0] <= meta_i;
         for (int i = 1; i < int'(DEPTH); i++) begin
            vld_q[i]  <= vld_q[i-1];
            meta_q[i] <= meta_q[i-1];
         end
      end
   end

   assign valid_o = vld_q[DEPTH-1];
   assign meta_o  = meta_q[DEPTH-1];

endmodule

// File: rtl/mdu_issue_scheduler.sv
// MDU issue scheduler: writeback-slot reservation, start pulses, writeback metadata.
// Optional register scoreboard enabled by defining MDU_SCOREBOARD_EN.
module mdu_issue_scheduler
   import mdu_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEF,
   parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   mdu_issue_scheduler_if.slave bus
);

   logic [DIV_LAT:1] res_q, res_d;
   logic             slot_conflict, hazard, handshake;
   int unsigned      lat;
   mdu_meta_t        meta_in, mul_meta_in, div_meta_in, mul_meta, div_meta, wb_meta;
   logic             mul_v, div_v;

   // Issue gating: the target writeback slot must be free and no register hazard pending.
   always_comb begin
      lat           = bus.issue_is_mul ? MUL_LAT : DIV_LAT;
      slot_conflict = bus.issue_is_mul ? res_q[MUL_LAT] : res_q[DIV_LAT];
   end

   assign bus.issue_ready = rst_n & ~slot_conflict & ~hazard;
   assign handshake       = bus.issue_valid & bus.issue_ready;
   assign bus.mul_start   = handshake & bus.issue_is_mul;
   assign bus.div_start   = handshake & ~bus.issue_is_mul;

   always_comb begin
      meta_in        = '0;
      meta_in.is_mul = bus.issue_is_mul;
      meta_in.funct3 = bus.issue_funct3;
      meta_in.rd     = bus.issue_rd;
      mul_meta_in    = bus.mul_start ? meta_in : '0;
      div_meta_in    = bus.div_start ? meta_in : '0;
   end

   // Reservation shifts toward 1 each cycle; a new op books the slot LAT-1 away from next cycle.
   always_comb begin
      res_d = {1'b0, res_q[DIV_LAT:2]};
      for (int unsigned k = 1; k <= DIV_LAT; k++) begin
         if (handshake && (k == lat - 1)) res_d[k] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_q <= '0;
      else        res_q <= res_d;
   end

   mdu_meta_delay #(.DEPTH(MUL_LAT)) u_mul_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bus.mul_start),
      .meta_i  (mul_meta_in),
      .valid_o (mul_v),
      .meta_o  (mul_meta)
   );

   mdu_meta_delay #(.DEPTH(DIV_LAT)) u_div_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bus.div_start),
      .meta_i  (div_meta_in),
      .valid_o (div_v),
      .meta_o  (div_meta)
   );

   // Reservation guarantees at most one line is valid; idle lines carry zero metadata.
   assign wb_meta       = mul_meta | div_meta;
   assign bus.wb_valid  = mul_v | div_v;
   assign bus.wb_is_mul = wb_meta.is_mul;
   assign bus.wb_funct3 = wb_meta.funct3;
   assign bus.wb_rd     = wb_meta.rd;
   assign bus.mdu_busy  = (|res_q) | bus.wb_valid;

`ifdef MDU_SCOREBOARD_EN
   logic [NREGS-1:0] pend_q, pend_d;

   assign hazard = |(pend_q & (reg_onehot(bus.issue_rs1) | reg_onehot(bus.issue_rs2) |
                               reg_onehot(bus.issue_rd)));

   always_comb begin
      pend_d = pend_q;
      if (bus.wb_valid) pend_d = pend_d & ~reg_onehot(bus.wb_rd);
      if (handshake && (bus.issue_rd != '0)) pend_d = pend_d | reg_onehot(bus.issue_rd);
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   assign bus.rd_pending = pend_q;
`else
   logic unused_src_regs;
   assign unused_src_regs = ^{bus.issue_rs1, bus.issue_rs2};
   assign hazard          = 1'b0;
   assign bus.rd_pending  = '0;
`endif

endmodule

// File: tb/tb_mdu_issue_scheduler.sv
// Bench for mdu_issue_scheduler: directed scenarios then random traffic against an in-flight-op list model.
module tb_mdu_issue_scheduler;
   import mdu_pkg::*;

   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_LAT = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mdu_issue_scheduler_if bus();

   mdu_issue_scheduler #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int       w;
      bit       is_mul;
      bit [2:0] f3;
      bit [4:0] rd;
   } op_t;

   op_t infl[$];
   int  now = 0;
   int  vectors = 0;
   int  miscompares = 0;
   bit  sb_en;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, now);
      end
   endtask

   // One clock cycle: drive after the edge, check mid-cycle, advance the model at the next edge.
   task automatic step(input bit rst, input bit v, input bit m, input bit [2:0] f3,
                       input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                       output bit acc);
      int       lat;
      bit       conf, haz, e_wb, e_wmul, e_busy, e_ready;
      bit [2:0] e_wf3;
      bit [4:0] e_wrd;
      logic [31:0] e_pend, one;
      op_t      o;
      #1;
      rst_n            = rst;
      bus.issue_valid  = v;
      bus.issue_is_mul = m;
      bus.issue_funct3 = f3;
      bus.issue_rd     = rd;
      bus.issue_rs1    = rs1;
      bus.issue_rs2    = rs2;
      if (!rst) infl.delete();
      lat = m ? int'(MUL_LAT) : int'(DIV_LAT);
      conf = 0; haz = 0; e_wb = 0; e_wmul = 0; e_wf3 = 0; e_wrd = 0; e_busy = 0; e_pend = 0;
      one = 32'd1;
      foreach (infl[i]) begin
         if (infl[i].w == now + lat) conf = 1;
         if (infl[i].w == now) begin
            e_wb = 1; e_wmul = infl[i].is_mul; e_wf3 = infl[i].f3; e_wrd = infl[i].rd;
         end
         e_busy = 1;
         if (sb_en && infl[i].rd != 0) begin
            e_pend = e_pend | (one << infl[i].rd);
            if (infl[i].rd == rs1 || infl[i].rd == rs2 || infl[i].rd == rd) haz = 1;
         end
      end
      e_ready = rst && !conf && !haz;
      @(negedge clk);
      chk("issue_ready", 32'(bus.issue_ready), 32'(e_ready));
      chk("mul_start",   32'(bus.mul_start),   32'(v && e_ready && m));
      chk("div_start",   32'(bus.div_start),   32'(v && e_ready && !m));
      chk("wb_valid",    32'(bus.wb_valid),    32'(e_wb));
      chk("wb_is_mul",   32'(bus.wb_is_mul),   32'(e_wmul));
      chk("wb_funct3",   32'(bus.wb_funct3),   32'(e_wf3));
      chk("wb_rd",       32'(bus.wb_rd),       32'(e_wrd));
      chk("rd_pending",  bus.rd_pending,       e_pend);
      chk("mdu_busy",    32'(bus.mdu_busy),    32'(e_busy));
      acc = v && e_ready;
      @(posedge clk);
      if (acc) begin
         o.w = now + lat; o.is_mul = m; o.f3 = f3; o.rd = rd;
         infl.push_back(o);
      end
      now++;
      for (int i = infl.size() - 1; i >= 0; i--) if (infl[i].w < now) infl.delete(i);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, a);
   endtask

   // Hold an op on the bus until the model says it is taken; bounded wait.
   task automatic offer(input bit m, input bit [2:0] f3, input bit [4:0] rd,
                        input bit [4:0] rs1, input bit [4:0] rs2);
      bit a;
      a = 0;
      for (int i = 0; i < 20 && !a; i++) step(1, 1, m, f3, rd, rs1, rs2, a);
      chk("offer_accept", 32'(a), 32'd1);
   endtask

   initial begin
      bit a;
`ifdef MDU_SCOREBOARD_EN
      sb_en = 1;
`else
      sb_en = 0;
`endif
      @(posedge clk);
      step(0, 1, 1, F3_MUL, 5'd5, 5'd1, 5'd2, a);
      step(0, 1, 0, F3_DIV, 5'd6, 5'd1, 5'd2, a);

      offer(1, F3_MUL, 5'd5, 5'd1, 5'd2);
      idle(6);

      offer(0, F3_DIV, 5'd3, 5'd1, 5'd2);
      idle(3);
      offer(1, F3_MULH, 5'd4, 5'd11, 5'd12);
      idle(10);

      offer(1, F3_MULHU, 5'd7, 5'd1, 5'd2);
      offer(1, F3_MUL, 5'd8, 5'd7, 5'd2);
      idle(6);

      for (int r = 1; r <= 4; r++) offer(1, F3_MULHSU, 5'(r), 5'd20, 5'd21);
      idle(6);

      offer(1, F3_MUL, 5'd0, 5'd1, 5'd2);
      offer(1, F3_MUL, 5'd9, 5'd0, 5'd0);
      idle(6);

      offer(0, F3_REMU, 5'd10, 5'd1, 5'd2);
      idle(2);
      step(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, a);
      step(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, a);
      offer(1, F3_MUL, 5'd10, 5'd10, 5'd0);
      idle(10);

      for (int i = 0; i < 400; i++) begin
         step(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a);
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
